pwm_run_sequencer: RTL and testbench
====================================

PWM_RUN_SEQUENCER -- requirements
Module: pwm_run_sequencer

Interface
REQ-001 The block SHALL have parameter N_CHAINS, default 2: number of PWM chains sequenced.
REQ-002 The block SHALL have parameter DELAY_WIDTH, default 16: width of the stagger delay counter.
REQ-003 The block SHALL have port clock, input, 1: single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start_req, input, 1: one-cycle request to start the chains.
REQ-006 The block SHALL have port stop_req, input, 1: one-cycle request for a graceful stop.
REQ-007 The block SHALL have port fault, input, 1: level-sensitive hard fault.
REQ-008 The block SHALL have port fault_clear, input, 1: one-cycle fault acknowledge.
REQ-009 The block SHALL have port period_end, input, N_CHAINS: per-chain counter period-boundary pulse.
REQ-010 The block SHALL have port stagger_delay, input, DELAY_WIDTH: cycles inserted between successive chain enables.
REQ-011 The block SHALL have port chain_run, output, N_CHAINS: per-chain run enable.
REQ-012 The block SHALL have port sync, output, 1: one-cycle counter synchronisation pulse.
REQ-013 The block SHALL have port state, output, 3: current FSM state code.
REQ-014 The block SHALL have port fault_latched, output, 1: sticky fault flag.
REQ-015 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states and codes IDLE=0, SYNC=1, STAGGER=2, RUNNING=3, STOPPING=4, FAULT=5.
REQ-017 All outputs SHALL be registered.
REQ-018 In IDLE, start_req with fault_latched=0 and fault=0 SHALL move the FSM to SYNC on the next cycle.
REQ-019 In SYNC, sync SHALL be high for exactly one cycle, and the FSM SHALL then move to STAGGER with chain index 0 and delay counter 0.
REQ-020 chain_run[0] SHALL rise in the first STAGGER cycle, which is the cycle after sync.
REQ-021 chain_run[i+1] SHALL rise exactly stagger_delay+1 cycles after chain_run[i].
REQ-022 With stagger_delay=0, chain enables SHALL occur on consecutive cycles.
REQ-023 stagger_delay SHALL be sampled once, on entry to STAGGER; later changes SHALL be ignored until the next start.
REQ-024 The FSM SHALL move to RUNNING in the cycle after chain_run[N_CHAINS-1] rises.
REQ-025 With N_CHAINS=1, the FSM SHALL go directly from STAGGER to RUNNING after one cycle.
REQ-026 In RUNNING, stop_req SHALL move the FSM to STOPPING.
REQ-027 In STAGGER, stop_req SHALL abort staggering and move the FSM to STOPPING, and chains not yet enabled SHALL remain 0.
REQ-028 In STOPPING, each chain_run[i] that is high SHALL clear on the cycle after period_end[i] is seen high.
REQ-029 Each period_end[i] SHALL be ignored for chains already at 0.
REQ-030 When all chain_run bits are 0, the FSM SHALL return to IDLE on the next cycle.
REQ-031 period_end pulses on several chains in the same cycle SHALL clear all of those chains together.
REQ-032 fault=1 in any non-FAULT state SHALL, on the next cycle, clear all chain_run bits, set fault_latched=1 and enter FAULT.
REQ-033 fault SHALL have priority over stop_req, and stop_req SHALL have priority over start_req.
REQ-034 In FAULT, start_req and stop_req SHALL be ignored.
REQ-035 In FAULT, fault_clear with fault=0 SHALL clear fault_latched and return the FSM to IDLE.
REQ-036 In FAULT, fault_clear while fault=1 SHALL be ignored.
REQ-037 start_req SHALL be ignored in SYNC, STAGGER, RUNNING and STOPPING.
REQ-038 stop_req SHALL be ignored in IDLE and SYNC; a stop_req arriving in SYNC SHALL be lost.
REQ-039 The delay counter SHALL be DELAY_WIDTH bits and compare-equal against the sampled stagger_delay; it SHALL not wrap before a match.

Reset
REQ-040 Reset SHALL be synchronous and active-high, and SHALL take priority over fault and all other inputs.
REQ-041 On reset the block SHALL set state=IDLE, chain_run=0, sync=0, fault_latched=0, busy=0, delay counter=0 and chain index=0.
REQ-042 Reset asserted mid-STAGGER or mid-STOPPING SHALL drop all chain_run bits on the next clock edge, with no wait for period_end.

Verification
REQ-043 Scenario (N_CHAINS=2, stagger_delay=3): start_req at cycle 0 -> sync=1 at cycle 1, chain_run=01 at cycle 2, chain_run=11 at cycle 6, state=RUNNING at cycle 7.
REQ-044 Scenario (graceful stop): stop_req in RUNNING, period_end=10 then period_end=01 two cycles later -> chain_run=01 one cycle after the first pulse, then 00, then state=IDLE one cycle later.
REQ-045 Scenario (stop during stagger): stagger_delay=10, stop_req 2 cycles after chain_run[0] rises -> chain_run[1] never rises, and chain 0 clears after its period_end.
REQ-046 Scenario (fault in RUNNING): fault=1 -> next cycle chain_run=00, fault_latched=1, state=5; fault_clear while fault=1 -> still state=5; fault=0 then fault_clear -> state=0; start_req then works normally.
REQ-047 Scenario (simultaneous inputs): fault, stop_req and start_req high in the same RUNNING cycle -> state=FAULT.
REQ-048 Scenario (reset mid-operation): reset in STOPPING with chain_run=11 -> next cycle chain_run=00, state=IDLE, busy=0.

Source files
------------

// File: rtl/pwm_run_sequencer.sv
// Start/stop/fault sequencer for a bank of PWM chains: issues a counter sync,
// staggers chain enables, retires chains on period boundaries on a graceful stop.
module pwm_run_sequencer #(
  parameter int N_CHAINS    = 2,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_req,
  input  logic                   stop_req,
  input  logic                   fault,
  input  logic                   fault_clear,
  input  logic [N_CHAINS-1:0]    period_end,
  input  logic [DELAY_WIDTH-1:0] stagger_delay,
  output logic [N_CHAINS-1:0]    chain_run,
  output logic                   sync,
  output logic [2:0]             state,
  output logic                   fault_latched,
  output logic                   busy
);

  localparam int IDX_W = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    STAGGER  = 3'd2,
    RUNNING  = 3'd3,
    STOPPING = 3'd4,
    FAULT    = 3'd5
  } state_e;

  state_e                 state_q;
  logic [N_CHAINS-1:0]    chain_run_q;
  logic                   sync_q;
  logic                   fault_latched_q;
  logic                   busy_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [DELAY_WIDTH-1:0] dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      chain_run_q     <= '0;
      sync_q          <= 1'b0;
      fault_latched_q <= 1'b0;
      busy_q          <= 1'b0;
      idx_q           <= '0;
      cnt_q           <= '0;
      dly_q           <= '0;
    end else begin
      sync_q <= 1'b0;
      // A live fault preempts every other request in all states but FAULT itself
      if (fault && (state_q != FAULT)) begin
        state_q         <= FAULT;
        chain_run_q     <= '0;
        fault_latched_q <= 1'b1;
        busy_q          <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_req && !fault_latched_q) begin
              state_q <= SYNC;
              sync_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          SYNC: begin
            state_q        <= STAGGER;
            chain_run_q    <= '0;
            chain_run_q[0] <= 1'b1;
            idx_q          <= '0;
            cnt_q          <= '0;
            dly_q          <= stagger_delay;
          end
          STAGGER: begin
            if (stop_req) begin
              state_q <= STOPPING;
            end else if (idx_q == IDX_W'(N_CHAINS - 1)) begin
              state_q <= RUNNING;
            end else if (cnt_q == dly_q) begin
              // Enables form a thermometer code, so the next chain is one shift up
              chain_run_q <= chain_run_q | (chain_run_q << 1);
              idx_q       <= idx_q + IDX_W'(1);
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + DELAY_WIDTH'(1);
            end
          end
          RUNNING: begin
            if (stop_req) state_q <= STOPPING;
          end
          STOPPING: begin
            if (chain_run_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              chain_run_q <= chain_run_q & ~period_end;
            end
          end
          FAULT: begin
            if (fault_clear && !fault) begin
              state_q         <= IDLE;
              fault_latched_q <= 1'b0;
              busy_q          <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            chain_run_q <= '0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chain_run     = chain_run_q;
  assign sync          = sync_q;
  assign state         = state_q;
  assign fault_latched = fault_latched_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pwm_run_sequencer.sv
// Vector-table bench for pwm_run_sequencer with N_CHAINS=2; expectations queued
// as each vector is driven and compared after the following clock edge.
module tb_pwm_run_sequencer;

  localparam int N  = 2;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_req;
  logic          stop_req;
  logic          fault;
  logic          fault_clear;
  logic [N-1:0]  period_end;
  logic [DW-1:0] stagger_delay;
  logic [N-1:0]  chain_run;
  logic          sync;
  logic [2:0]    state;
  logic          fault_latched;
  logic          busy;

  pwm_run_sequencer #(.N_CHAINS(N), .DELAY_WIDTH(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .period_end    (period_end),
    .stagger_delay (stagger_delay),
    .chain_run     (chain_run),
    .sync          (sync),
    .state         (state),
    .fault_latched (fault_latched),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst, st, sp, flt, fc;
    logic [1:0]    pe;
    logic [DW-1:0] dly;
    logic [2:0]    e_state;
    logic [1:0]    e_run;
    logic          e_sync, e_flt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic v(input logic rst, st, sp, flt, fc, input logic [1:0] pe,
                   input int dly, input int es, input logic [1:0] er,
                   input logic esync, eflt);
    vec_t t;
    t.rst = rst; t.st = st; t.sp = sp; t.flt = flt; t.fc = fc; t.pe = pe;
    t.dly = DW'(dly); t.e_state = 3'(es); t.e_run = er; t.e_sync = esync; t.e_flt = eflt;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    reset = 0; start_req = 0; stop_req = 0; fault = 0; fault_clear = 0; period_end = '0;
  endtask

  initial begin
    vec_t e;
    int   n;
    reset = 1; start_req = 0; stop_req = 0; fault = 0; fault_clear = 0;
    period_end = '0; stagger_delay = '0;

    //  rst st sp fl fc pe     dly  state run    sy fl
    v(1, 0, 0, 0, 0, 2'b00, 0,  0, 2'b00, 0, 0);   // reset state
    v(0, 1, 0, 0, 0, 2'b00, 3,  1, 2'b00, 1, 0);   // start -> SYNC, sync pulse
    v(0, 0, 0, 0, 0, 2'b00, 3,  2, 2'b01, 0, 0);   // chain0 up, delay=3 sampled
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);   // later delay change ignored
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b11, 0, 0);   // chain1 four cycles later
    v(0, 0, 0, 0, 0, 2'b00, 0,  3, 2'b11, 0, 0);   // RUNNING
    v(0, 1, 0, 0, 0, 2'b00, 0,  3, 2'b11, 0, 0);   // start ignored in RUNNING
    v(0, 0, 1, 0, 0, 2'b00, 0,  4, 2'b11, 0, 0);   // stop -> STOPPING
    v(0, 0, 0, 0, 0, 2'b10, 0,  4, 2'b01, 0, 0);   // chain1 retires
    v(0, 0, 0, 0, 0, 2'b00, 0,  4, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b01, 0,  4, 2'b00, 0, 0);   // chain0 retires
    v(0, 0, 0, 0, 0, 2'b00, 0,  0, 2'b00, 0, 0);   // back to IDLE
    v(0, 0, 1, 0, 0, 2'b00, 0,  0, 2'b00, 0, 0);   // stop ignored in IDLE
    v(0, 1, 0, 0, 0, 2'b00, 10, 1, 2'b00, 1, 0);   // stop during stagger
    v(0, 0, 0, 0, 0, 2'b00, 10, 2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 10, 2, 2'b01, 0, 0);
    v(0, 0, 1, 0, 0, 2'b00, 10, 4, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b10, 10, 4, 2'b01, 0, 0);   // pulse on idle chain ignored
    v(0, 0, 0, 0, 0, 2'b01, 10, 4, 2'b00, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 10, 0, 2'b00, 0, 0);
    v(0, 1, 0, 0, 0, 2'b00, 0,  1, 2'b00, 1, 0);   // zero delay
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b11, 0, 0);   // consecutive enables
    v(0, 0, 0, 0, 0, 2'b00, 0,  3, 2'b11, 0, 0);
    v(0, 1, 1, 1, 0, 2'b00, 0,  5, 2'b00, 0, 1);   // fault beats stop and start
    v(0, 0, 0, 1, 1, 2'b00, 0,  5, 2'b00, 0, 1);   // clear while faulted ignored
    v(0, 1, 1, 0, 0, 2'b00, 0,  5, 2'b00, 0, 1);   // start/stop ignored in FAULT
    v(0, 0, 0, 0, 1, 2'b00, 0,  0, 2'b00, 0, 0);   // clear -> IDLE
    v(0, 1, 0, 0, 0, 2'b00, 1,  1, 2'b00, 1, 0);   // restart after fault
    v(0, 0, 0, 0, 0, 2'b00, 1,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 1,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 1,  2, 2'b11, 0, 0);
    v(0, 0, 1, 0, 0, 2'b00, 1,  4, 2'b11, 0, 0);   // stop on last stagger cycle
    v(0, 0, 0, 0, 0, 2'b11, 1,  4, 2'b00, 0, 0);   // simultaneous period ends
    v(0, 0, 0, 0, 0, 2'b00, 1,  0, 2'b00, 0, 0);
    v(0, 1, 0, 0, 0, 2'b00, 0,  1, 2'b00, 1, 0);   // reset mid-STOPPING
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b11, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  3, 2'b11, 0, 0);
    v(0, 0, 1, 0, 0, 2'b00, 0,  4, 2'b11, 0, 0);
    v(1, 0, 0, 1, 0, 2'b00, 0,  0, 2'b00, 0, 0);   // reset beats fault
    v(0, 0, 0, 0, 0, 2'b00, 0,  0, 2'b00, 0, 0);
    v(0, 1, 0, 0, 0, 2'b00, 0,  1, 2'b00, 1, 0);   // fault in SYNC
    v(0, 0, 0, 1, 0, 2'b00, 0,  5, 2'b00, 0, 1);
    v(0, 0, 0, 0, 1, 2'b00, 0,  0, 2'b00, 0, 0);
    v(0, 1, 0, 0, 0, 2'b00, 0,  1, 2'b00, 1, 0);   // stop in SYNC is lost
    v(0, 0, 1, 0, 0, 2'b00, 0,  2, 2'b01, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  2, 2'b11, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  3, 2'b11, 0, 0);
    v(0, 0, 1, 0, 0, 2'b00, 0,  4, 2'b11, 0, 0);
    v(0, 0, 0, 0, 0, 2'b11, 0,  4, 2'b00, 0, 0);
    v(0, 0, 0, 0, 0, 2'b00, 0,  0, 2'b00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst; start_req = vecs[i].st; stop_req = vecs[i].sp;
      fault = vecs[i].flt; fault_clear = vecs[i].fc; period_end = vecs[i].pe;
      stagger_delay = vecs[i].dly;
      sb.push_back(vecs[i]);
      @(posedge clock); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_state", i), int'(state), int'(e.e_state));
      chk($sformatf("v%0d_chain_run", i), int'(chain_run), int'(e.e_run));
      chk($sformatf("v%0d_sync", i), int'(sync), int'(e.e_sync));
      chk($sformatf("v%0d_fault_latched", i), int'(fault_latched), int'(e.e_flt));
      chk($sformatf("v%0d_busy", i), int'(busy), (e.e_state != 3'd0) ? 1 : 0);
    end

    // Stagger gap measured directly for a delay of 5
    @(negedge clock);
    idle_inputs(); stagger_delay = 16'd5; start_req = 1;
    @(negedge clock);
    start_req = 0;
    n = 0;
    while (!chain_run[0] && n < 20) begin @(posedge clock); #1; n++; end
    chk("gap_chain0_rise", int'(chain_run[0]), 1);
    n = 0;
    while (!chain_run[1] && n < 40) begin @(posedge clock); #1; n++; end
    chk("gap_chain1_delay", n, 6);
    @(posedge clock); #1;
    chk("gap_running", int'(state), 3);
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    chk("gap_reset_run", int'(chain_run), 0);
    reset = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
